// File: rtl/dac_frame_scheduler.sv
// Four-channel DAC frame scheduler: arbitrates sample requests and serializes 24-bit frames.
// Define DAC_FIXED_PRIO_EN for fixed-priority arbitration (ch0 highest) instead of round-robin.
module dac_frame_scheduler #(
   parameter int unsigned GAP_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  req,
   input  logic [63:0] data,
   output logic [3:0]  ack,
   output logic        sync,
   output logic        din,
   output logic        clk_out,
   output logic        busy,
   output logic [1:0]  grant_ch,
   output logic        frame_done
);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      GAP
   } state_t;

   state_t      state, state_nxt;
   logic [4:0]  bitcnt, bitcnt_nxt;
   logic [3:0]  gapcnt, gapcnt_nxt;
   logic [23:0] shreg, shreg_nxt;
   logic        sync_nxt, din_nxt, busy_nxt, frame_done_nxt;
   logic [3:0]  ack_nxt;
   logic [1:0]  grant_nxt;

   logic [1:0]  win_ch;
   logic        win_valid;
   logic [15:0] win_sample;
   logic [23:0] win_frame;
   logic        capture;

   assign clk_out = clk;

`ifdef DAC_FIXED_PRIO_EN
   always_comb begin
      win_ch    = '0;
      win_valid = 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
         if (!win_valid && req[i]) begin
            win_ch    = 2'(i);
            win_valid = 1'b1;
         end
      end
   end
`else
   logic [1:0] rr_last;
   logic [1:0] rr_idx;

   // Search begins one past the last winner; 2-bit arithmetic gives the mod-4 wrap.
   always_comb begin
      win_ch    = '0;
      win_valid = 1'b0;
      rr_idx    = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         rr_idx = rr_last + 2'd1 + 2'(i);
         if (!win_valid && req[rr_idx]) begin
            win_ch    = rr_idx;
            win_valid = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_last <= 2'd3;
      end else if (capture) begin
         rr_last <= win_ch;
      end
   end
`endif

   assign win_sample = data[{win_ch, 4'b0000} +: 16];
   assign win_frame  = {5'b00010, win_ch, 1'b0, win_sample};

   always_comb begin
      state_nxt      = state;
      bitcnt_nxt     = bitcnt;
      gapcnt_nxt     = gapcnt;
      shreg_nxt      = shreg;
      sync_nxt       = sync;
      din_nxt        = din;
      busy_nxt       = busy;
      grant_nxt      = grant_ch;
      ack_nxt        = '0;
      frame_done_nxt = 1'b0;
      capture        = 1'b0;

      case (state)
         SHIFT: begin
            if (bitcnt == 5'd23) begin
               state_nxt      = GAP;
               gapcnt_nxt     = '0;
               sync_nxt       = 1'b1;
               din_nxt        = 1'b1;
               frame_done_nxt = 1'b1;
            end else begin
               bitcnt_nxt = bitcnt + 5'd1;
               din_nxt    = shreg[23];
               shreg_nxt  = {shreg[22:0], 1'b0};
            end
         end
         GAP: begin
            if (gapcnt == 4'(GAP_CYCLES - 1)) begin
               capture = win_valid;
            end else begin
               gapcnt_nxt = gapcnt + 4'd1;
            end
         end
         default: begin
            capture = win_valid;
         end
      endcase

      // Arbitration point reached (IDLE or last GAP cycle): start a frame or fall back to IDLE.
      if (state == IDLE || (state == GAP && gapcnt == 4'(GAP_CYCLES - 1))) begin
         if (win_valid) begin
            state_nxt       = SHIFT;
            bitcnt_nxt      = '0;
            shreg_nxt       = {win_frame[22:0], 1'b0};
            din_nxt         = win_frame[23];
            sync_nxt        = 1'b0;
            busy_nxt        = 1'b1;
            grant_nxt       = win_ch;
            ack_nxt[win_ch] = 1'b1;
         end else begin
            state_nxt = IDLE;
            sync_nxt  = 1'b1;
            din_nxt   = 1'b1;
            busy_nxt  = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         bitcnt     <= '0;
         gapcnt     <= '0;
         shreg      <= '0;
         sync       <= 1'b1;
         din        <= 1'b1;
         busy       <= 1'b0;
         grant_ch   <= '0;
         ack        <= '0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         bitcnt     <= bitcnt_nxt;
         gapcnt     <= gapcnt_nxt;
         shreg      <= shreg_nxt;
         sync       <= sync_nxt;
         din        <= din_nxt;
         busy       <= busy_nxt;
         grant_ch   <= grant_nxt;
         ack        <= ack_nxt;
         frame_done <= frame_done_nxt;
      end
   end

endmodule

// File: doc/dac_frame_scheduler.md
DAC_FRAME_SCHEDULER -- requirements
Module: dac_frame_scheduler

Interface
REQ-001 Parameter: GAP_CYCLES, default 2, number of sync-high cycles between back-to-back frames (legal range 1..15).
REQ-002 Port: clk, input, 1, system clock; also the DAC serial clock.
REQ-003 Port: rst_n, input, 1, reset; the block SHALL use one clock (clk) and an asynchronous, active-low reset (rst_n).
REQ-004 Port: req, input, 4, per-channel frame request; bit n = channel n.
REQ-005 Port: data, input, 64, packed samples; channel n sample = data[16n+15:16n].
REQ-006 Port: ack, output, 4, one-cycle pulse, bit n = channel n sample captured.
REQ-007 Port: sync, output, 1, DAC frame strobe, low during the 24 frame bits.
REQ-008 Port: din, output, 1, DAC serial data, MSB first.
REQ-009 Port: clk_out, output, 1, DAC serial clock, SHALL equal clk combinationally.
REQ-010 Port: busy, output, 1, high in SHIFT and GAP.
REQ-011 Port: grant_ch, output, 2, channel of the current or most recent frame.
REQ-012 Port: frame_done, output, 1, one-cycle pulse in the cycle after the last frame bit.

Function
REQ-013 FSM states: IDLE, SHIFT, GAP; sync, din, ack, busy, grant_ch and frame_done SHALL be registered.
REQ-014 Arbitration SHALL occur only in IDLE and in the final GAP cycle; if any req bit is high, the winner's sample and channel SHALL be captured on that edge, and the FSM SHALL enter SHIFT.
REQ-015 Frame = {5'b00010, ch[1:0], 1'b0, sample[15:0]}, 24 bits; headers are 0x10/0x12/0x14/0x16 for ch0..3.
REQ-016 SHIFT: for exactly 24 cycles starting the cycle after capture, sync=0 and din=frame[23-bitcnt], with bitcnt running 0..23.
REQ-017 ack[ch] SHALL be high only in the first SHIFT cycle; the requester SHALL drop req in that cycle, and a req still high at the next arbitration point is a new request.
REQ-018 After bit 23, the FSM SHALL enter GAP with sync=1 and din=1 for GAP_CYCLES cycles; frame_done SHALL pulse in the first GAP cycle.
REQ-019 When GAP ends with no req, the FSM SHALL enter IDLE with sync=1, din=1 and busy=0.
REQ-020 Round-robin: the search SHALL start at (last granted + 1) mod 4, and the first requesting channel wins.
REQ-021 Unserved req bits SHALL remain pending without loss; req or data changes during SHIFT/GAP SHALL not affect the frame in flight.
REQ-022 Continuous requests on all channels SHALL yield frames ch0,1,2,3,0,... with exactly GAP_CYCLES sync-high cycles between frames (frame period 24+GAP_CYCLES).
REQ-023 grant_ch SHALL update on the capture edge and hold until the next capture.

Reset
REQ-024 rst_n low SHALL immediately force state=IDLE, sync=1, din=1, ack=0, busy=0, frame_done=0, grant_ch=0, bitcnt=0 and the round-robin pointer so that ch0 wins first.
REQ-025 Reset mid-frame SHALL abort the frame; the aborted frame SHALL not resume and SHALL not produce frame_done.
REQ-026 The first arbitration SHALL occur on the first clk edge after rst_n deasserts.

Configuration
REQ-027 Macro DAC_FIXED_PRIO_EN: when defined, arbitration SHALL be fixed priority (ch0 highest, ch3 lowest) and the round-robin pointer SHALL be omitted.
REQ-028 Without DAC_FIXED_PRIO_EN, arbitration SHALL be round-robin per REQ-020.

Verification
REQ-029 req=4'b0001, data[15:0]=0x8C8B -> ack=0001 for one cycle, sync low 24 cycles, din stream 0x108C8B MSB first, then frame_done; busy low after 2 GAP cycles.
REQ-030 req=4'b1111 held continuously, samples distinct -> headers 0x10,0x12,0x14,0x16,0x10 in order, each frame period 26 cycles (GAP_CYCLES=2).
REQ-031 req=4'b0100 raised at bit 10 of a ch0 frame -> ch2 frame starts after exactly GAP_CYCLES sync-high cycles, header 0x14, no lost request.
REQ-032 rst_n pulsed low at bit 12 of a ch3 frame -> sync=1, din=1 in the same cycle, no frame_done; next req=0001 is served normally.
REQ-033 data changed during SHIFT -> serialized sample equals the value captured at arbitration.
REQ-034 DAC_FIXED_PRIO_EN defined, req=4'b1111 held -> only ch0 frames, header 0x10 every frame.
